pool_seq_ctrl: RTL and testbench

Parametrised sequencing controller for the max-pool datapath. It sits between the pool read bridge, the pool unit and the pool write bridge. On a start pulse it programs the read bridge's initial address, then queues pooled-window positions from the read bridge. It answers write-bridge address requests with output addresses, one request per channel group, and pulses done once the image has fully drained.

---
 rtl/pool_seq_ctrl.sv | 162 ++++++++++++++++
 tb/tb_pool_seq_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pool_seq_ctrl.sv
// Sequencing controller for the max-pool datapath: programs the read bridge, queues
// pooled-window positions and hands per-channel-group output addresses to the write bridge.
module pool_seq_ctrl #(
   parameter int ADDR_W = 28,
   parameter int IMG_W  = 64,
   parameter int IMG_H  = 64,
   parameter int CH     = 64,
   parameter int LANES  = 16,
   parameter int POOL_K = 2,
   parameter int STRIDE = 2,
   parameter int DEPTH  = 4
) (
   input  logic                                              clk,
   input  logic                                              rst_n,
   input  logic                                              start,
   input  logic [ADDR_W-1:0]                                 cfg_rd_base,
   input  logic [ADDR_W-1:0]                                 cfg_wr_base,
   output logic                                              busy,
   output logic                                              done,
   output logic                                              err,
   output logic                                              rd_init_en,
   output logic [ADDR_W-1:0]                                 rd_init_addr,
   input  logic                                              rd_pt_en,
   input  logic [$clog2((IMG_W > IMG_H) ? IMG_W : IMG_H)-1:0] rd_ptr,
   input  logic [$clog2((IMG_W > IMG_H) ? IMG_W : IMG_H)-1:0] rd_ptc,
   input  logic                                              rd_img_end,
   output logic                                              rd_stall,
   input  logic                                              wr_addr_rq,
   output logic                                              wr_addr_en,
   output logic [ADDR_W-1:0]                                 wr_addr,
   output logic [$clog2(CH):0]                               wr_bias
);

   localparam int OUT_W = (IMG_W - POOL_K) / STRIDE + 1;
   localparam int OUT_H = (IMG_H - POOL_K) / STRIDE + 1;
   localparam int NGRP  = CH / LANES;
   localparam int PW    = $clog2((IMG_W > IMG_H) ? IMG_W : IMG_H);
   localparam int BW    = $clog2(CH) + 1;
   localparam int SH    = $clog2(STRIDE);
   localparam int FAW   = $clog2(DEPTH);
   localparam int CW    = FAW + 1;
   localparam int GW    = (NGRP > 1) ? $clog2(NGRP) : 1;

   typedef enum logic [2:0] {S_IDLE, S_INIT, S_RUN, S_DRAIN, S_DONE} state_t;

   typedef struct packed {
      logic [PW-1:0] row;
      logic [PW-1:0] col;
   } pos_t;

   state_t            state;
   pos_t              fifo_mem [DEPTH];
   logic [FAW-1:0]    head_ptr;
   logic [FAW-1:0]    tail_ptr;
   logic [CW-1:0]     count;
   logic [GW-1:0]     grp;
   logic [ADDR_W-1:0] wr_base_q;

   int                pt_row;
   int                pt_col;
   logic              pt_ok;
   pos_t              new_pos;
   pos_t              head;
   logic [ADDR_W-1:0] pix_off;

   logic fifo_empty, fifo_full, serve, pop, pt_valid, push, pt_err;

   // Window positions must sit on the stride grid and inside the pooled output.
   always_comb begin
      pt_row  = int'(rd_ptr) >> SH;
      pt_col  = int'(rd_ptc) >> SH;
      pt_ok   = ((int'(rd_ptr) & (STRIDE - 1)) == 0) &&
                ((int'(rd_ptc) & (STRIDE - 1)) == 0) &&
                (pt_row < OUT_H) && (pt_col < OUT_W);
      new_pos = '{row: PW'(pt_row), col: PW'(pt_col)};
   end

   assign fifo_empty = (count == '0);
   assign fifo_full  = (count == CW'(DEPTH));
   assign rd_stall   = fifo_full;

   assign serve    = ((state == S_RUN) || (state == S_DRAIN)) && wr_addr_rq && !fifo_empty;
   assign pop      = serve && (grp == GW'(NGRP - 1));
   assign pt_valid = (state == S_RUN) && rd_pt_en;
   // A full FIFO still takes a position when the head leaves in the same cycle.
   assign push     = pt_valid && pt_ok && (!fifo_full || pop);
   assign pt_err   = pt_valid && !push;

   assign head    = fifo_mem[head_ptr];
   assign pix_off = (ADDR_W'(head.row) * ADDR_W'(OUT_W) + ADDR_W'(head.col)) * ADDR_W'(CH);

   // NOTE: the entry storage has no reset; occupancy is defined entirely by the
   // pointers and count, and an entry is never read before it has been written.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[tail_ptr] <= new_pos;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         busy         <= 1'b0;
         done         <= 1'b0;
         err          <= 1'b0;
         rd_init_en   <= 1'b0;
         rd_init_addr <= '0;
         wr_addr_en   <= 1'b0;
         wr_addr      <= '0;
         wr_bias      <= '0;
         wr_base_q    <= '0;
         head_ptr     <= '0;
         tail_ptr     <= '0;
         count        <= '0;
         grp          <= '0;
      end else begin
         // NOTE: strobes default low here; a later non-blocking assignment in this
         // block overrides the default for the cycle it must be high.
         rd_init_en <= 1'b0;
         done       <= 1'b0;
         wr_addr_en <= 1'b0;

         if (serve) begin
            wr_addr_en <= 1'b1;
            wr_addr    <= wr_base_q + pix_off;
            wr_bias    <= BW'(grp) * BW'(LANES);
            grp        <= pop ? '0 : grp + GW'(1);
         end

         if (push) tail_ptr <= tail_ptr + FAW'(1);
         if (pop)  head_ptr <= head_ptr + FAW'(1);
         if (push && !pop)      count <= count + CW'(1);
         else if (pop && !push) count <= count - CW'(1);

         if (pt_err) err <= 1'b1;

         case (state)
            S_IDLE: begin
               if (start) begin
                  state        <= S_INIT;
                  busy         <= 1'b1;
                  err          <= 1'b0;
                  wr_base_q    <= cfg_wr_base;
                  rd_init_en   <= 1'b1;
                  rd_init_addr <= cfg_rd_base;
               end
            end
            S_INIT:  state <= S_RUN;
            S_RUN:   if (rd_img_end) state <= S_DRAIN;
            S_DRAIN: if (fifo_empty && (grp == '0)) state <= S_DONE;
            S_DONE: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pool_seq_ctrl.sv
// Scoreboard bench for pool_seq_ctrl on an 8x8 image, 2x2/2 pooling, 8 channels in 4-lane groups.
module tb_pool_seq_ctrl;

   localparam int ADDR_W = 28;
   localparam int IMG_W  = 8;
   localparam int IMG_H  = 8;
   localparam int CH     = 8;
   localparam int LANES  = 4;
   localparam int POOL_K = 2;
   localparam int STRIDE = 2;
   localparam int DEPTH  = 4;
   localparam int OUT_W  = 4;
   localparam int PW     = 3;
   localparam int BW     = 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic [ADDR_W-1:0] cfg_rd_base = '0;
   logic [ADDR_W-1:0] cfg_wr_base = '0;
   logic              busy, done, err, rd_init_en, rd_stall, wr_addr_en;
   logic [ADDR_W-1:0] rd_init_addr, wr_addr;
   logic              rd_pt_en = 1'b0;
   logic [PW-1:0]     rd_ptr = '0;
   logic [PW-1:0]     rd_ptc = '0;
   logic              rd_img_end = 1'b0;
   logic              wr_addr_rq = 1'b0;
   logic [BW-1:0]     wr_bias;

   pool_seq_ctrl #(
      .ADDR_W(ADDR_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .CH(CH), .LANES(LANES),
      .POOL_K(POOL_K), .STRIDE(STRIDE), .DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .cfg_rd_base(cfg_rd_base),
      .cfg_wr_base(cfg_wr_base), .busy(busy), .done(done), .err(err),
      .rd_init_en(rd_init_en), .rd_init_addr(rd_init_addr), .rd_pt_en(rd_pt_en),
      .rd_ptr(rd_ptr), .rd_ptc(rd_ptc), .rd_img_end(rd_img_end), .rd_stall(rd_stall),
      .wr_addr_rq(wr_addr_rq), .wr_addr_en(wr_addr_en), .wr_addr(wr_addr), .wr_bias(wr_bias)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [BW-1:0]     bias;
   } resp_t;

   resp_t             sb[$];
   int                n_vec = 0;
   int                n_err = 0;
   int                done_cnt = 0;
   int                resp_cnt = 0;
   logic [ADDR_W-1:0] cur_wr_base = '0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Output monitor: every response must match the head of the scoreboard.
   always @(negedge clk) begin
      resp_t e;
      if (done) done_cnt++;
      if (wr_addr_en) begin
         resp_cnt++;
         check("resp_expected", 64'(sb.size() > 0), 64'(1));
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("wr_addr", 64'(wr_addr), 64'(e.addr));
            check("wr_bias", 64'(wr_bias), 64'(e.bias));
         end
      end
   end

   function automatic logic [ADDR_W-1:0] exp_addr(input int r, input int c);
      return cur_wr_base + ADDR_W'(((r / STRIDE) * OUT_W + (c / STRIDE)) * CH);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [ADDR_W-1:0] rb, input logic [ADDR_W-1:0] wb);
      cfg_rd_base = rb;
      cfg_wr_base = wb;
      cur_wr_base = wb;
      start = 1'b1;
      step();
      start = 1'b0;
      cfg_rd_base = ~rb;
      cfg_wr_base = ~wb;
      @(negedge clk);
      check("init_en_pulse", 64'(rd_init_en), 64'(1));
      check("init_addr", 64'(rd_init_addr), 64'(rb));
      check("start_clears_err", 64'(err), 64'(0));
      check("busy_after_start", 64'(busy), 64'(1));
      step();
      @(negedge clk);
      check("init_en_low", 64'(rd_init_en), 64'(0));
      check("init_addr_hold", 64'(rd_init_addr), 64'(rb));
   endtask

   task automatic push_pos(input int r, input int c, input bit ok, input bit with_end);
      rd_pt_en = 1'b1;
      rd_ptr = PW'(r);
      rd_ptc = PW'(c);
      rd_img_end = with_end;
      if (ok) begin
         sb.push_back('{addr: exp_addr(r, c), bias: BW'(0)});
         sb.push_back('{addr: exp_addr(r, c), bias: BW'(LANES)});
      end
      step();
      rd_pt_en = 1'b0;
      rd_img_end = 1'b0;
   endtask

   task automatic serve_all(input bit with_end, output int cyc);
      cyc = 0;
      wr_addr_rq = 1'b1;
      rd_img_end = with_end;
      while (sb.size() > 0 && cyc < 60) begin
         step();
         rd_img_end = 1'b0;
         cyc++;
      end
      wr_addr_rq = 1'b0;
      check("serve_drained", 64'(sb.size()), 64'(0));
   endtask

   task automatic end_image();
      rd_img_end = 1'b1;
      step();
      rd_img_end = 1'b0;
   endtask

   task automatic wait_done();
      int d0;
      int n;
      d0 = done_cnt;
      n = 0;
      while (done_cnt == d0 && n < 40) begin
         step();
         n++;
      end
      check("done_seen", 64'(done_cnt != d0), 64'(1));
      repeat (3) step();
      @(negedge clk);
      check("done_once", 64'(done_cnt - d0), 64'(1));
      check("busy_low", 64'(busy), 64'(0));
   endtask

   task automatic check_all_zero();
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_done", 64'(done), 64'(0));
      check("rst_err", 64'(err), 64'(0));
      check("rst_init_en", 64'(rd_init_en), 64'(0));
      check("rst_init_addr", 64'(rd_init_addr), 64'(0));
      check("rst_stall", 64'(rd_stall), 64'(0));
      check("rst_wr_en", 64'(wr_addr_en), 64'(0));
      check("rst_wr_addr", 64'(wr_addr), 64'(0));
      check("rst_wr_bias", 64'(wr_bias), 64'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      int r0;

      // Reset state
      repeat (2) @(negedge clk);
      check_all_zero();
      rst_n = 1'b1;
      step();

      // Basic single position, two channel groups
      do_start(28'h40, 28'h100);
      push_pos(2, 4, 1'b1, 1'b0);
      serve_all(1'b0, cyc);
      @(negedge clk);
      check("basic_addr_hold", 64'(wr_addr), 64'(28'h130));
      check("basic_bias_hold", 64'(wr_bias), 64'(LANES));
      check("basic_err", 64'(err), 64'(0));
      end_image();
      wait_done();

      // Back-to-back serving with image end during the run
      do_start(28'h80, 28'h100);
      push_pos(0, 0, 1'b1, 1'b0);
      push_pos(0, 2, 1'b1, 1'b0);
      push_pos(6, 6, 1'b1, 1'b0);
      serve_all(1'b1, cyc);
      check("b2b_cycles", 64'(cyc), 64'(7));
      wait_done();

      // Full FIFO: accept with simultaneous pop, drop without
      do_start(28'h0, 28'h4000);
      push_pos(0, 0, 1'b1, 1'b0);
      push_pos(2, 2, 1'b1, 1'b0);
      push_pos(4, 4, 1'b1, 1'b0);
      push_pos(6, 0, 1'b1, 1'b0);
      @(negedge clk);
      check("full_stall", 64'(rd_stall), 64'(1));
      wr_addr_rq = 1'b1;
      step();
      push_pos(0, 6, 1'b1, 1'b0);
      wr_addr_rq = 1'b0;
      @(negedge clk);
      check("full_pop_err", 64'(err), 64'(0));
      check("full_pop_stall", 64'(rd_stall), 64'(1));
      push_pos(2, 0, 1'b0, 1'b0);
      @(negedge clk);
      check("full_drop_err", 64'(err), 64'(1));
      serve_all(1'b0, cyc);
      end_image();
      wait_done();

      // Misaligned positions are dropped with an error and no response
      do_start(28'h10, 28'h200);
      r0 = resp_cnt;
      push_pos(3, 0, 1'b0, 1'b0);
      push_pos(0, 5, 1'b0, 1'b0);
      wr_addr_rq = 1'b1;
      repeat (5) step();
      wr_addr_rq = 1'b0;
      @(negedge clk);
      check("bad_err", 64'(err), 64'(1));
      check("bad_no_resp", 64'(resp_cnt - r0), 64'(0));
      end_image();
      wait_done();

      // Corner: last position coincides with image end (start also clears err)
      do_start(28'h20, 28'hFFFFF00);
      push_pos(4, 2, 1'b1, 1'b1);
      serve_all(1'b0, cyc);
      wait_done();

      // Reset while draining with two entries queued
      do_start(28'h55, 28'h300);
      push_pos(2, 6, 1'b1, 1'b0);
      serve_all(1'b0, cyc);
      push_pos(1, 0, 1'b0, 1'b0);
      push_pos(4, 4, 1'b0, 1'b0);
      push_pos(6, 2, 1'b0, 1'b0);
      end_image();
      repeat (2) step();
      @(negedge clk);
      check("drain_busy", 64'(busy), 64'(1));
      check("drain_err", 64'(err), 64'(1));
      rst_n = 1'b0;
      #2;
      check_all_zero();
      @(negedge clk);
      rst_n = 1'b1;
      step();
      do_start(28'h60, 28'h500);
      push_pos(6, 4, 1'b1, 1'b0);
      serve_all(1'b0, cyc);
      end_image();
      wait_done();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
